// File: rtl/pe_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_pkg
// Description : Shared types, ConfigBits field layout and config decode for
//               the PE ALU result accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_acc_pkg;

  // Operating mode after decode; the raw 2'b11 encoding never survives decode
  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_SUM  = 2'b01,
    MODE_MAX  = 2'b10
  } mode_e;

  // Reduction FSM states
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

  // ConfigBits layout: [1:0] mode, [2 +: CNT_WIDTH] reduction length
  localparam int c_CFG_MODE_LSB = 0;
  localparam int c_CFG_MODE_W   = 2;
  localparam int c_CFG_N_LSB    = 2;

  // Widest reduction-length field the length decode handles
  localparam int c_LEN_MAX_W    = 32;

  // A length of one (or zero) has nothing to reduce, so it collapses to PASS.
  // Raw 2'b11 is reserved and also behaves as PASS.
  function automatic mode_e decode_mode(input logic [c_CFG_MODE_W-1:0] raw,
                                        input logic                    len_is_one);
    if (len_is_one) begin
      return MODE_PASS;
    end
    case (raw)
      2'b01:   return MODE_SUM;
      2'b10:   return MODE_MAX;
      default: return MODE_PASS;
    endcase
  endfunction

  // N=0 is treated as N=1
  function automatic logic [c_LEN_MAX_W-1:0] decode_len(input logic [c_LEN_MAX_W-1:0] raw);
    return (raw == '0) ? c_LEN_MAX_W'(1) : raw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_out_stage.sv
`default_nettype none
// ============================================================================
// Module      : pe_out_stage
// Description : One-entry valid/ready output register with load and flush.
//               A load in the same cycle as a consume keeps the stage full,
//               which gives full throughput in pass-through use.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_out_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_flush,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Output register: flush beats load, load beats consume
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pe_alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : pe_alu_accumulator
// Description : Registered valid/ready stage behind the PE ALU. Acts as a
//               pipeline register (PASS), a modulo running-sum reducer (SUM)
//               or a signed-max reducer (MAX) over N ALU results.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_alu_accumulator
  import pe_acc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [2+CNT_WIDTH-1:0] ConfigBits,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  // Configuration decode and latch
  logic [CNT_WIDTH-1:0] w_cfg_n_raw;
  logic [CNT_WIDTH-1:0] w_cfg_n;
  mode_e                w_cfg_mode;
  mode_e                r_mode;
  logic [CNT_WIDTH-1:0] r_n;
  mode_e                w_mode;
  logic [CNT_WIDTH-1:0] w_n;

  // FSM and datapath
  state_e               r_state;
  state_e               w_state_next;
  logic [WIDTH-1:0]     r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_reduce;
  logic                 w_last;
  logic                 w_load;
  logic                 w_busy;
  logic                 w_out_valid;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_max;
  logic [WIDTH-1:0]     w_acc_next;
  logic [WIDTH-1:0]     w_out_next;

  assign w_cfg_n_raw = ConfigBits[c_CFG_N_LSB +: CNT_WIDTH];
  assign w_cfg_n     = CNT_WIDTH'(decode_len(c_LEN_MAX_W'(w_cfg_n_raw)));
  assign w_cfg_mode  = decode_mode(ConfigBits[c_CFG_MODE_LSB +: c_CFG_MODE_W],
                                   w_cfg_n == CNT_WIDTH'(1));

  assign w_busy = (r_cnt != '0) || w_out_valid;

  // While idle the live ConfigBits apply immediately; once busy the latched copy
  // is frozen so a mid-reduction config change cannot corrupt the result.
  assign w_mode = w_busy ? r_mode : w_cfg_mode;
  assign w_n    = w_busy ? r_n    : w_cfg_n;

  // Configuration latch, refreshed whenever the stage is idle
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mode <= MODE_PASS;
      r_n    <= CNT_WIDTH'(1);
    end else if (!w_busy) begin
      r_mode <= w_cfg_mode;
      r_n    <= w_cfg_n;
    end
  end

  assign w_reduce = (w_mode != MODE_PASS);
  assign w_accept = in_valid && w_in_ready;
  assign w_last   = (r_cnt == (w_n - CNT_WIDTH'(1)));

  // Reduction FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Reduction FSM next-state logic; PASS mode never leaves ACCUM
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_reduce && w_accept && w_last) w_state_next = ST_EMIT;
        ST_EMIT:  if (w_out_valid && out_ready)       w_state_next = ST_ACCUM;
        default:  w_state_next = ST_ACCUM;
      endcase
    end
  end

  // Reduction FSM outputs: input handshake and output-register load
  always_comb begin
    w_in_ready = 1'b0;
    if (RST || clear) begin
      w_in_ready = 1'b0;
    end else if (!w_reduce) begin
      w_in_ready = !w_out_valid || out_ready;
    end else begin
      w_in_ready = (r_state == ST_ACCUM);
    end
    w_load = w_accept && (!w_reduce || w_last);
  end

  // First accept of a reduction seeds the accumulator with the raw input
  always_comb begin
    w_sum      = r_acc + in_data;
    w_max      = ($signed(in_data) > $signed(r_acc)) ? in_data : r_acc;
    w_acc_next = in_data;
    if (r_cnt != '0) begin
      w_acc_next = (w_mode == MODE_SUM) ? w_sum : w_max;
    end
    w_out_next = w_reduce ? w_acc_next : in_data;
  end

  // Accumulator and reduction counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_accept && w_reduce) begin
      r_acc <= w_acc_next;
      r_cnt <= w_last ? '0 : r_cnt + CNT_WIDTH'(1);
    end
  end

  pe_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_load),
    .i_data  (w_out_next),
    .i_flush (clear),
    .i_ready (out_ready),
    .o_data  (out_data),
    .o_valid (w_out_valid)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_pe_alu_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_alu_accumulator
// Description : Directed self-checking bench for pe_alu_accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_alu_accumulator;

  logic        CLK;
  logic        RST;
  logic [9:0]  ConfigBits;
  logic        clear;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  pe_alu_accumulator #(
    .WIDTH     (32),
    .CNT_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ConfigBits (ConfigBits),
    .clear      (clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic set_cfg(input logic [1:0] m, input logic [7:0] n);
    ConfigBits = {n, m};
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tick; tick;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (out_data !== 32'h0) begin failed++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    RST = 1'b0; in_valid = 1'b0;
    tick;
  endtask

  task automatic test_pass_stream;
    set_cfg(2'b00, 8'd1); out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      #1;
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL pass_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick;
      tests++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin failed++; $display("FAIL pass_out[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 32'(i)); end
    end
    in_valid = 1'b0;
    tick;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL pass_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_pass_stall;
    set_cfg(2'b00, 8'd1); out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5;
    tick;
    in_data = 32'hB6;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA5) begin failed++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=000000a5", i, in_ready, out_valid, out_data); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    tick;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'hB6) begin failed++; $display("FAIL stall_next: got v=%b d=%h expected v=1 d=000000b6", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL stall_drain: got v=%b busy=%b expected v=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_sum_wrap;
    logic [31:0] v [4];
    v[0] = 32'hFFFF_FFFF; v[1] = 32'd1; v[2] = 32'd2; v[3] = 32'd3;
    set_cfg(2'b01, 8'd4); out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = v[i];
      #1;
      tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL sum_in_ready[%0d]: got %b expected 1", i, in_ready); end
      tick;
      if (i < 3) begin
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL sum_early[%0d]: got out_valid=%b expected 0", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'h5) begin failed++; $display("FAIL sum_result: got v=%b d=%h expected v=1 d=00000005", out_valid, out_data); end
    tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL sum_emit: got rdy=%b busy=%b expected rdy=0 busy=1", in_ready, busy); end
    in_valid = 1'b1; in_data = 32'd77;
    for (int i = 0; i < 2; i++) begin
      tick;
      tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h5) begin failed++; $display("FAIL sum_hold[%0d]: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=00000005", i, in_ready, out_valid, out_data); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL sum_consume: got v=%b busy=%b expected v=0 busy=0", out_valid, busy); end
  endtask

  task automatic test_max;
    logic [31:0] v [6];
    logic [31:0] exp_res [2];
    v[0] = 32'hFFFF_FFFB; v[1] = 32'd7;         v[2] = 32'hFFFF_FFFF;
    v[3] = 32'hFFFF_FFF8; v[4] = 32'hFFFF_FFFD; v[5] = 32'hFFFF_FFFD;
    exp_res[0] = 32'd7; exp_res[1] = 32'hFFFF_FFFD;
    set_cfg(2'b10, 8'd3); out_ready = 1'b1;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1; in_data = v[g*3+i];
        tick;
      end
      in_valid = 1'b0;
      tests++; if (out_valid !== 1'b1 || out_data !== exp_res[g]) begin failed++; $display("FAIL max_result[%0d]: got v=%b d=%h expected v=1 d=%h", g, out_valid, out_data, exp_res[g]); end
      tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL max_emit_ready[%0d]: got %b expected 0", g, in_ready); end
      tick;
      tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL max_consume[%0d]: got out_valid=%b expected 0", g, out_valid); end
    end
  endtask

  task automatic test_config_hold;
    set_cfg(2'b01, 8'd2); out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd5;
    tick;
    set_cfg(2'b00, 8'd1);
    tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failed++; $display("FAIL cfg_busy: got v=%b busy=%b expected v=0 busy=1", out_valid, busy); end
    in_data = 32'd6;
    tick;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd11) begin failed++; $display("FAIL cfg_frozen_sum: got v=%b d=%h expected v=1 d=0000000b", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
    in_valid = 1'b1; in_data = 32'd9;
    tick;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd9) begin failed++; $display("FAIL cfg_new_pass: got v=%b d=%h expected v=1 d=00000009", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_clear;
    set_cfg(2'b01, 8'd4); out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd10; tick;
    in_data = 32'd20; tick;
    clear = 1'b1; in_data = 32'd99;
    #1;
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL clear_in_ready: got %b expected 0", in_ready); end
    tick;
    clear = 1'b0; in_valid = 1'b0;
    tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failed++; $display("FAIL clear_flush: got busy=%b v=%b expected busy=0 v=0", busy, out_valid); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'd1;
      tick;
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd4) begin failed++; $display("FAIL clear_resum: got v=%b d=%h expected v=1 d=00000004", out_valid, out_data); end
    tick;
  endtask

  task automatic test_reset_mid;
    set_cfg(2'b01, 8'd3); out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'd7; tick;
    in_data = 32'd8; tick;
    RST = 1'b1; in_data = 32'd9;
    #1;
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL rstmid_in_ready: got %b expected 0", in_ready); end
    tick;
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0) begin failed++; $display("FAIL rstmid_state: got v=%b d=%h busy=%b expected v=0 d=00000000 busy=0", out_valid, out_data, busy); end
    RST = 1'b0; in_valid = 1'b0;
    tick;
    set_cfg(2'b01, 8'd0);
    in_valid = 1'b1; in_data = 32'd42;
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL n0_in_ready: got %b expected 1", in_ready); end
    tick;
    tests++; if (out_valid !== 1'b1 || out_data !== 32'd42) begin failed++; $display("FAIL n0_result: got v=%b d=%h expected v=1 d=0000002a", out_valid, out_data); end
    in_valid = 1'b0;
    tick;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL n0_consume: got out_valid=%b expected 0", out_valid); end
  endtask

  initial begin
    RST = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; ConfigBits = '0;
    test_reset;
    test_pass_stream;
    test_pass_stall;
    test_sum_wrap;
    test_max;
    test_config_hold;
    test_clear;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pe_alu_accumulator.md
# pe_alu_accumulator

Downstream stage of the PE tile's ALU: consumes the ALU result stream and presents a registered, handshaked output to the tile's output routing. Depending on configuration it acts as a plain pipeline register, a running-sum reducer over N results, or a signed-max reducer over N results. It adds the PE's only state on the ALU result path and gives the fabric router a valid/ready boundary.

## Interface
- WIDTH, 32, data width; matches ALU Y width.
- CNT_WIDTH, 8, width of the reduction-length field.
- CLK  in  1  tile clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ConfigBits  in  2+CNT_WIDTH  [1:0] = mode (00 PASS, 01 SUM, 10 MAX, 11 treated as PASS); [2+CNT_WIDTH-1:2] = N, the reduction length. Static; changes take effect only while busy=0.
- clear  in  1  synchronous flush of partial reduction and output register.
- in_data  in  WIDTH  ALU result.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  stage accepts in_data this cycle.
- out_data  out  WIDTH  registered result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  reduction in progress or output pending.

## Operation
- Input handshake: accept when in_valid && in_ready. Output handshake: consume when out_valid && out_ready.
- N=0 is treated as N=1. SUM/MAX with N=1 behave exactly like PASS.
- PASS: one-entry pipeline register. in_ready = !out_valid || out_ready (combinational from out_ready). An accepted input loads out_data and sets out_valid. Simultaneous accept and consume gives full throughput.
- SUM/MAX state machine:
  - ACCUM: in_ready=1. On each accept, acc <= op(acc, in_data) and cnt <= cnt+1. The first accept after entering ACCUM loads acc <= in_data. On the accept where cnt == N-1, load out_data <= op(acc, in_data), set out_valid, clear cnt, and go to EMIT.
  - EMIT: in_ready=0. On consume, clear out_valid and go to ACCUM.
- SUM: addition modulo 2^WIDTH; carry is discarded and there is no saturation.
- MAX: two's-complement signed compare. On a tie, the held value is kept.
- busy = (cnt != 0) || out_valid.
- clear: the next state is ACCUM with cnt=0, out_valid=0 and acc unchanged (it is don't-care). in_ready=0 during a clear cycle, so an input presented in the same cycle is not accepted. clear overrides a simultaneous output consume.
- A ConfigBits change while busy=1 is ignored until busy returns to 0. The effective configuration is latched internally when busy=0.

## Timing
- Reset values: out_valid=0, out_data=0, state=ACCUM, cnt=0, acc=0, latched mode=PASS. in_ready=0 while RST=1.
- Latency: 1 cycle from the accepting edge of the final (or only) input to out_valid=1.
- PASS throughput: 1 result per cycle while out_ready=1.
- SUM/MAX throughput: N inputs, then at least 1 EMIT cycle. Minimum period is N+1 cycles per result.
- Reset or clear mid-reduction discards the partial result; no output is produced for it.
- Holding rule: out_data and out_valid are stable while out_valid && !out_ready.

## Structure
- Shared package pe_acc_pkg holds:
  - the mode enum (PASS/SUM/MAX) and state enum (ACCUM/EMIT);
  - ConfigBits field offsets;
  - the config-decode function mapping 11→PASS and N=0→1.
- Natural sub-module: pe_out_stage, a one-entry valid/ready output register with load and flush inputs. It is used for out_data/out_valid in all modes.
- The reduction datapath (adder, signed comparator, acc/cnt registers) and the FSM live in pe_alu_accumulator.

## Test plan
- PASS, out_ready=1, inputs 1,2,3 on consecutive cycles → out_data 1,2,3 on the following consecutive cycles, in_ready held 1.
- PASS, out_ready=0 for 3 cycles with input 0xA5 → out_data stays 0xA5 with out_valid=1, in_ready=0. Raising out_ready → consumed, and the next input is accepted in the same cycle.
- SUM, N=4, inputs 0xFFFFFFFF,1,2,3 → single output 0x00000005 (wrap), one cycle after the 4th accept; in_ready=0 until consumed.
- MAX, N=3, inputs -5 (0xFFFFFFFB), 7, -1 → output 7; then N=3, inputs -8,-3,-3 → output 0xFFFFFFFD.
- SUM, N=4: accept 10,20, then assert clear together with in_valid (in_data=99) → 99 is not accepted, busy=0. Then inputs 1,1,1,1 → output 4.
- RST asserted mid-reduction (SUM, N=3, after 2 accepts) → next cycle out_valid=0, out_data=0, busy=0, in_ready=0 during reset. N=0 configured with input 42 → output 42 after 1 cycle.
